// File: rtl/sys_arr_pkg.sv
// Shared systolic-array package: row container, writeback FSM states and the
// default row/destination widths used by the GSAU writeback path.
package sys_arr_pkg;

    localparam int WB_ROW_W = 512;
    localparam int WB_DST_W = 8;

    // One completed partial-sum row and the vector register it is bound for.
    typedef struct packed {
        logic [WB_ROW_W-1:0] psum;
        logic [WB_DST_W-1:0] vdst;
    } wb_row_t;

    // IDLE: nothing held. WRITE: hold register is driving beats.
    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } wb_state_t;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gsau_wb_fifo.sv
// Show-ahead circular FIFO of writeback rows. Pointers carry one extra wrap
// bit so full and empty are told apart without a separate counter; the
// occupancy is simply the pointer difference.
module gsau_wb_fifo
    import sys_arr_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type row_t = wb_row_t,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  row_t        wdata,
    input  logic        pop,
    output row_t        rdata,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);

    row_t        mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Storage needs no reset; only slots between rd_ptr and wr_ptr are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // Pointer advance; the caller only pushes when not full and pops when not empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Head is always visible so a pop and a load happen in the same cycle.
    always_comb begin
        rdata = mem[rd_ptr[AW-1:0]];
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        count = wr_ptr - rd_ptr;
    end

endmodule

// File: rtl/gsau_wb_buffer.sv
// GSAU writeback buffer: queues completed partial-sum rows, drains each one
// into the veggie file write port as BEATS narrower beats, then pulses a done
// report carrying the destination register.
//
// Build option GSAU_WB_BYPASS_EN: when defined, a row arriving while the
// buffer is completely idle loads the hold register directly (first beat one
// cycle earlier, wb_count stays 0). When undefined every row goes through the
// FIFO.
//
// Handshakes (valid/ready): a transfer happens on a rising edge where both
// valid and ready are high. The producer keeps valid and its payload stable
// until that edge; ready may be high or low regardless of valid. Here that
// applies to wb_valid/wb_output_ready (row in) and veg_wr_en/veg_wr_ready
// (beat out); while a beat waits for veg_wr_ready all beat outputs hold.
module gsau_wb_buffer
    import sys_arr_pkg::*;
#(
    parameter int  DEPTH  = 4,
    parameter int  ROW_W  = WB_ROW_W,
    parameter int  WR_W   = 128,
    parameter int  DST_W  = WB_DST_W,
    localparam int BEATS  = ROW_W / WR_W,
    localparam int BEAT_W = clog2_min1(BEATS),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              wb_valid,
    input  logic [ROW_W-1:0]  wb_psum,
    input  logic [DST_W-1:0]  wb_wbdst,
    output logic              wb_output_ready,
    output logic              veg_wr_en,
    output logic [DST_W-1:0]  veg_wr_vdst,
    output logic [BEAT_W-1:0] veg_wr_beat,
    output logic [WR_W-1:0]   veg_wr_data,
    input  logic              veg_wr_ready,
    output logic              sb_done_valid,
    output logic [DST_W-1:0]  sb_done_vdst,
    output logic [CNT_W-1:0]  wb_count,
    output wb_state_t         dbg_state
);

    typedef struct packed {
        logic [ROW_W-1:0] psum;
        logic [DST_W-1:0] vdst;
    } row_t;

    wb_state_t         state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    row_t              hold_q;
    logic              done_valid_q;
    logic [DST_W-1:0]  done_vdst_q;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    row_t              fifo_rdata;
    row_t              in_row;
    logic              load_fifo;
    logic              load_in;
    logic              beat_acc;
    logic              last_acc;

    gsau_wb_fifo #(
        .DEPTH (DEPTH),
        .row_t (row_t)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (nRST),
        .push  (fifo_push),
        .wdata (in_row),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (wb_count)
    );

    // Input row packing and beat-acceptance qualifiers.
    always_comb begin
        in_row.psum = wb_psum;
        in_row.vdst = wb_wbdst;
        beat_acc    = (state_q == WRITE) && veg_wr_ready;
        last_acc    = beat_acc && (beat_q == BEAT_W'(BEATS - 1));
    end

    // Next-state logic: refill the hold register from the FIFO head with no bubble.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        fifo_pop  = 1'b0;
        load_fifo = 1'b0;
        load_in   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    load_fifo = 1'b1;
                    state_d   = WRITE;
                    beat_d    = '0;
                end
`ifdef GSAU_WB_BYPASS_EN
                else if (wb_valid) begin
                    // Empty FIFO means ready is high, so the row is accepted here.
                    load_in = 1'b1;
                    state_d = WRITE;
                    beat_d  = '0;
                end
`endif
            end
            WRITE: begin
                if (last_acc) begin
                    beat_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        load_fifo = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (beat_acc) begin
                    beat_d = beat_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Readiness depends on occupancy only, never on a same-cycle pop.
    always_comb begin
        wb_output_ready = !fifo_full;
        fifo_push       = wb_valid && !fifo_full && !load_in;
    end

    // State, beat counter and done report registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            done_valid_q <= 1'b0;
            done_vdst_q  <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            done_valid_q <= last_acc;
            if (last_acc) begin
                done_vdst_q <= hold_q.vdst;
            end
        end
    end

    // Hold register: loaded from the FIFO head, or straight from the input on bypass.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hold_q <= '0;
        end else if (load_fifo) begin
            hold_q <= fifo_rdata;
        end else if (load_in) begin
            hold_q <= in_row;
        end
    end

    // Beat outputs are zero whenever nothing is being written.
    always_comb begin
        veg_wr_en     = (state_q == WRITE);
        veg_wr_beat   = beat_q;
        veg_wr_vdst   = veg_wr_en ? hold_q.vdst : '0;
        veg_wr_data   = veg_wr_en ? hold_q.psum[int'(beat_q) * WR_W +: WR_W] : '0;
        sb_done_valid = done_valid_q;
        sb_done_vdst  = done_vdst_q;
        dbg_state     = state_q;
    end

endmodule

// File: tb/tb_gsau_wb_buffer.sv
// Bench for gsau_wb_buffer: directed scenarios plus a randomised stream, with
// a beat/done scoreboard filled whenever a row is accepted.
module tb_gsau_wb_buffer;
  import sys_arr_pkg::*;

  localparam int DEPTH  = 4;
  localparam int ROW_W  = 512;
  localparam int WR_W   = 128;
  localparam int DST_W  = 8;
  localparam int BEATS  = 4;
  localparam int BEAT_W = 2;
  localparam int CNT_W  = 3;
  localparam int REC_W  = DST_W + BEAT_W + WR_W;
`ifdef GSAU_WB_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic              CLK;
  logic              nRST;
  logic              wb_valid;
  logic [ROW_W-1:0]  wb_psum;
  logic [DST_W-1:0]  wb_wbdst;
  logic              wb_output_ready;
  logic              veg_wr_en;
  logic [DST_W-1:0]  veg_wr_vdst;
  logic [BEAT_W-1:0] veg_wr_beat;
  logic [WR_W-1:0]   veg_wr_data;
  logic              veg_wr_ready;
  logic              sb_done_valid;
  logic [DST_W-1:0]  sb_done_vdst;
  logic [CNT_W-1:0]  wb_count;
  wb_state_t         dbg_state;

  logic [REC_W-1:0]  exp_q[$];
  logic [DST_W-1:0]  exp_done_q[$];
  logic [REC_W-1:0]  rec;
  logic [DST_W-1:0]  exp_dst;
  int total;
  int bad;
  int done_seen;
  int cyc;

  gsau_wb_buffer #(
    .DEPTH (DEPTH),
    .ROW_W (ROW_W),
    .WR_W  (WR_W),
    .DST_W (DST_W)
  ) dut (
    .CLK             (CLK),
    .nRST            (nRST),
    .wb_valid        (wb_valid),
    .wb_psum         (wb_psum),
    .wb_wbdst        (wb_wbdst),
    .wb_output_ready (wb_output_ready),
    .veg_wr_en       (veg_wr_en),
    .veg_wr_vdst     (veg_wr_vdst),
    .veg_wr_beat     (veg_wr_beat),
    .veg_wr_data     (veg_wr_data),
    .veg_wr_ready    (veg_wr_ready),
    .sb_done_valid   (sb_done_valid),
    .sb_done_vdst    (sb_done_vdst),
    .wb_count        (wb_count),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  always @(negedge CLK) begin
    if (nRST) begin
      if (wb_valid && wb_output_ready) begin
        for (int b = 0; b < BEATS; b++) begin
          exp_q.push_back({wb_wbdst, BEAT_W'(b), wb_psum[b*WR_W +: WR_W]});
        end
        exp_done_q.push_back(wb_wbdst);
      end
      if (veg_wr_en && veg_wr_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL beat_unexpected: got vdst=%h beat=%0d, none expected", veg_wr_vdst, veg_wr_beat);
        end else begin
          rec = exp_q.pop_front();
          if ({veg_wr_vdst, veg_wr_beat, veg_wr_data} !== rec) begin
            bad++;
            $display("FAIL beat_data: got vdst=%h beat=%0d data=%h, want vdst=%h beat=%0d data=%h",
                     veg_wr_vdst, veg_wr_beat, veg_wr_data,
                     rec[REC_W-1 -: DST_W], rec[WR_W +: BEAT_W], rec[WR_W-1:0]);
          end
        end
      end
      if (sb_done_valid) begin
        done_seen++;
        total++;
        if (exp_done_q.size() == 0) begin
          bad++;
          $display("FAIL done_unexpected: got vdst=%h, none expected", sb_done_vdst);
        end else begin
          exp_dst = exp_done_q.pop_front();
          if (sb_done_vdst !== exp_dst) begin
            bad++;
            $display("FAIL done_vdst: got %h want %h", sb_done_vdst, exp_dst);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [ROW_W-1:0] word_row(input int base);
    logic [ROW_W-1:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = 32'(base + i);
    return r;
  endfunction

  function automatic logic [ROW_W-1:0] rand_row();
    logic [ROW_W-1:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic push_row(input logic [DST_W-1:0] dst, input logic [ROW_W-1:0] psum);
    logic acc;
    acc = 1'b0;
    wb_valid = 1'b1;
    wb_wbdst = dst;
    wb_psum  = psum;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge CLK);
      acc = wb_output_ready;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL push_timeout: dst=%h never accepted", dst);
    end
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic wait_beat(input int beat, input int budget);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      if (veg_wr_en && veg_wr_beat == BEAT_W'(beat)) hit = 1'b1;
      else tick();
    end
    if (!hit) begin
      total++;
      bad++;
      $display("FAIL wait_beat_timeout: beat %0d not seen", beat);
    end
  endtask

  task automatic drain(input int budget);
    logic empty;
    empty = 1'b0;
    veg_wr_ready = 1'b1;
    for (int i = 0; i < budget && !empty; i++) begin
      if (exp_q.size() == 0 && exp_done_q.size() == 0) empty = 1'b1;
      else tick();
    end
    total++;
    if (!empty || dbg_state !== IDLE || veg_wr_en !== 1'b0) begin
      bad++;
      $display("FAIL drain: beats_left=%0d dones_left=%0d state=%0d en=%b want 0 0 IDLE 0",
               exp_q.size(), exp_done_q.size(), dbg_state, veg_wr_en);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic check_reset_outputs(input string tag);
    total++;
    if (veg_wr_en !== 1'b0 || veg_wr_beat !== '0 || veg_wr_vdst !== '0 || veg_wr_data !== '0 ||
        sb_done_valid !== 1'b0 || sb_done_vdst !== '0 || wb_count !== '0 ||
        wb_output_ready !== 1'b1 || dbg_state !== IDLE) begin
      bad++;
      $display("FAIL %s: en=%b beat=%0d vdst=%h data=%h done=%b dvdst=%h count=%0d rdy=%b state=%0d, want all 0 with rdy=1 IDLE",
               tag, veg_wr_en, veg_wr_beat, veg_wr_vdst, veg_wr_data, sb_done_valid,
               sb_done_vdst, wb_count, wb_output_ready, dbg_state);
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    wb_valid = 1'b0;
    wb_psum = '0;
    wb_wbdst = '0;
    veg_wr_ready = 1'b0;
    #12;
    check_reset_outputs("reset_state");
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    tick();
    check_reset_outputs("after_reset_release");
  endtask

  task automatic test_single();
    veg_wr_ready = 1'b1;
    wb_valid = 1'b1;
    wb_wbdst = 8'h21;
    wb_psum  = word_row(0);
    tick();
    wb_valid = 1'b0;
    total++;
    if (LAT == 2 && (veg_wr_en !== 1'b0 || wb_count !== 3'd1)) begin
      bad++;
      $display("FAIL single_t1: en=%b count=%0d want en=0 count=1", veg_wr_en, wb_count);
    end else if (LAT == 1 && (veg_wr_en !== 1'b1 || wb_count !== 3'd0)) begin
      bad++;
      $display("FAIL single_t1: en=%b count=%0d want en=1 count=0", veg_wr_en, wb_count);
    end
    if (LAT == 2) tick();
    total++;
    if (veg_wr_en !== 1'b1 || veg_wr_beat !== 2'd0 || veg_wr_vdst !== 8'h21 ||
        veg_wr_data !== {32'd3, 32'd2, 32'd1, 32'd0}) begin
      bad++;
      $display("FAIL single_first_beat: en=%b beat=%0d vdst=%h data=%h want 1 0 21 words 3..0",
               veg_wr_en, veg_wr_beat, veg_wr_vdst, veg_wr_data);
    end
    for (int b = 1; b < BEATS; b++) begin
      tick();
      total++;
      if (veg_wr_en !== 1'b1 || veg_wr_beat !== BEAT_W'(b) || sb_done_valid !== 1'b0) begin
        bad++;
        $display("FAIL single_beat: en=%b beat=%0d done=%b want 1 %0d 0",
                 veg_wr_en, veg_wr_beat, sb_done_valid, b);
      end
    end
    tick();
    total++;
    if (sb_done_valid !== 1'b1 || sb_done_vdst !== 8'h21 || veg_wr_en !== 1'b0) begin
      bad++;
      $display("FAIL single_done: done=%b vdst=%h en=%b want 1 21 0", sb_done_valid, sb_done_vdst, veg_wr_en);
    end
    tick();
    total++;
    if (sb_done_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_done_pulse: done=%b want 0", sb_done_valid);
    end
  endtask

  task automatic test_stall();
    logic [DST_W-1:0]  s_vdst;
    logic [WR_W-1:0]   s_data;
    veg_wr_ready = 1'b1;
    push_row(8'h33, word_row(100));
    wait_beat(2, 20);
    veg_wr_ready = 1'b0;
    s_vdst = veg_wr_vdst;
    s_data = veg_wr_data;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (veg_wr_en !== 1'b1 || veg_wr_beat !== 2'd2 || veg_wr_vdst !== 8'h33 ||
          veg_wr_data !== s_data || veg_wr_vdst !== s_vdst || sb_done_valid !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold: en=%b beat=%0d vdst=%h data=%h done=%b want 1 2 33 %h 0",
                 veg_wr_en, veg_wr_beat, veg_wr_vdst, veg_wr_data, sb_done_valid, s_data);
      end
    end
    drain(40);
  endtask

  task automatic test_fill();
    int t[5];
    int n;
    veg_wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_row(8'h40 + 8'(i), word_row(200 + 16 * i));
    total++;
    if (wb_count !== 3'd4 || wb_output_ready !== 1'b0 || veg_wr_en !== 1'b1 ||
        veg_wr_beat !== 2'd0 || veg_wr_vdst !== 8'h40) begin
      bad++;
      $display("FAIL fill_full: count=%0d rdy=%b en=%b beat=%0d vdst=%h want 4 0 1 0 40",
               wb_count, wb_output_ready, veg_wr_en, veg_wr_beat, veg_wr_vdst);
    end
    wb_valid = 1'b1;
    wb_wbdst = 8'h99;
    wb_psum  = word_row(900);
    tick();
    tick();
    wb_valid = 1'b0;
    total++;
    if (wb_count !== 3'd4 || wb_output_ready !== 1'b0) begin
      bad++;
      $display("FAIL fill_reject: count=%0d rdy=%b want 4 0", wb_count, wb_output_ready);
    end
    veg_wr_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 60 && n < 5; i++) begin
      tick();
      if (sb_done_valid) begin
        t[n] = cyc;
        n++;
      end
    end
    total++;
    if (n != 5) begin
      bad++;
      $display("FAIL fill_done_count: got %0d want 5", n);
    end else begin
      for (int k = 1; k < 5; k++) begin
        total++;
        if (t[k] - t[k-1] != BEATS) begin
          bad++;
          $display("FAIL fill_spacing: got %0d cycles want %0d", t[k] - t[k-1], BEATS);
        end
      end
    end
    drain(40);
  endtask

  task automatic test_simul_push_pop();
    veg_wr_ready = 1'b1;
    push_row(8'h50, word_row(300));
    push_row(8'h51, word_row(316));
    wait_beat(3, 20);
    wb_valid = 1'b1;
    wb_wbdst = 8'h52;
    wb_psum  = word_row(332);
    @(negedge CLK);
    total++;
    if (wb_count !== 3'd1 || wb_output_ready !== 1'b1 || veg_wr_vdst !== 8'h50) begin
      bad++;
      $display("FAIL simul_before: count=%0d rdy=%b vdst=%h want 1 1 50", wb_count, wb_output_ready, veg_wr_vdst);
    end
    tick();
    wb_valid = 1'b0;
    total++;
    if (wb_count !== 3'd1 || veg_wr_en !== 1'b1 || veg_wr_beat !== 2'd0 || veg_wr_vdst !== 8'h51) begin
      bad++;
      $display("FAIL simul_after: count=%0d en=%b beat=%0d vdst=%h want 1 1 0 51",
               wb_count, veg_wr_en, veg_wr_beat, veg_wr_vdst);
    end
    drain(60);
  endtask

  task automatic test_reset_mid();
    veg_wr_ready = 1'b1;
    push_row(8'h77, word_row(400));
    wait_beat(1, 20);
    #2;
    nRST = 1'b0;
    #1;
    check_reset_outputs("reset_mid_row");
    exp_q.delete();
    exp_done_q.delete();
    tick();
    tick();
    nRST = 1'b1;
    tick();
    total++;
    if (sb_done_valid !== 1'b0 || veg_wr_en !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_done: done=%b en=%b want 0 0", sb_done_valid, veg_wr_en);
    end
    push_row(8'h05, word_row(450));
    drain(40);
  endtask

  task automatic test_dup_dst();
    int start;
    start = done_seen;
    veg_wr_ready = 1'b1;
    push_row(8'h10, word_row(600));
    push_row(8'h10, word_row(700));
    drain(60);
    total++;
    if (done_seen - start != 2) begin
      bad++;
      $display("FAIL dup_done_count: got %0d want 2", done_seen - start);
    end
  endtask

  task automatic test_back_to_back_random();
    fork
      begin
        for (int i = 0; i < 10; i++) push_row(8'($urandom_range(0, 255)), rand_row());
      end
      begin
        for (int i = 0; i < 80; i++) begin
          veg_wr_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
      end
    join
    drain(200);
  endtask

  initial begin
    total = 0;
    bad = 0;
    done_seen = 0;
    test_reset();
    test_single();
    test_stall();
    test_fill();
    test_simul_push_pop();
    test_reset_mid();
    test_dup_dst();
    test_back_to_back_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gsau_wb_buffer.md
# gsau_wb_buffer

Writeback buffer sitting directly downstream of the GSAU control unit. It accepts completed partial-sum rows (512 bits plus an 8-bit destination vector register) on a valid/ready handshake and queues them. It drains each row into the veggie file write port as a sequence of narrower beats, then reports each completed destination to the scoreboard so the register can be released.

## Interface
Parameters:
- DEPTH, 4: number of queued rows (power of two, ≥2).
- ROW_W, 512: partial-sum row width in bits.
- WR_W, 128: veggie write-port width in bits; ROW_W must be an integer multiple of WR_W; BEATS = ROW_W/WR_W.
- DST_W, 8: destination register index width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  asynchronous, active-low reset.
- wb_valid  in  1  GSAU presents a row.
- wb_psum  in  ROW_W  row data.
- wb_wbdst  in  DST_W  destination register.
- wb_output_ready  out  1  buffer can accept a row.
- veg_wr_en  out  1  write beat valid.
- veg_wr_vdst  out  DST_W  destination register of the current beat.
- veg_wr_beat  out  $clog2(BEATS) (minimum 1)  beat index within the row.
- veg_wr_data  out  WR_W  beat data.
- veg_wr_ready  in  1  veggie file accepts the beat.
- sb_done_valid  out  1  one-cycle pulse: row fully written.
- sb_done_vdst  out  DST_W  register just completed.
- wb_count  out  $clog2(DEPTH+1)  rows queued in the FIFO; excludes the row held for writing.

## Operation
- Rows are pushed into an internal show-ahead FIFO when wb_valid && wb_output_ready.
- wb_output_ready = !fifo_full. It is purely combinational and is not raised by a same-cycle pop.
- FSM states:
  - IDLE: no row held.
  - WRITE: the hold register drives beats.
- IDLE → WRITE when the FIFO is non-empty. The FIFO head is popped into the hold register (psum, vdst) and the beat counter is cleared.
- In WRITE:
  - veg_wr_en=1.
  - veg_wr_data = hold_psum[beat*WR_W +: WR_W].
  - veg_wr_beat = beat.
  - veg_wr_vdst = hold_vdst.
  - On veg_wr_ready the beat counter increments.
  - Without veg_wr_ready, all outputs hold stable.
- Last-beat acceptance (beat == BEATS-1 && veg_wr_ready):
  - Register sb_done_valid=1 and sb_done_vdst=hold_vdst for the next cycle only.
  - If the FIFO is non-empty, pop the head into the hold register, clear the counter and stay in WRITE (no bubble).
  - Otherwise go to IDLE.
- Rows retire strictly in arrival order. There is no reordering or merging. Two rows with the same wb_wbdst are written twice.
- A FIFO push and a pop in the same cycle are both honoured; wb_count is unchanged.

## Timing
- Reset (asynchronous, nRST low) values:
  - FSM=IDLE, FIFO empty, wb_count=0, wb_output_ready=1.
  - veg_wr_en=0, veg_wr_beat=0, veg_wr_vdst=0, veg_wr_data=0.
  - sb_done_valid=0, sb_done_vdst=0.
- Reset mid-row discards all queued and held rows. No done pulse is issued for them.
- Base latency: a row accepted in cycle T with an empty buffer gives its first beat (veg_wr_en=1) in cycle T+2.
- Write duration: with veg_wr_ready held high, a row takes BEATS cycles. sb_done_valid pulses in the cycle after the last beat.
- Throughput: with veg_wr_ready held high, rows stream back to back at one row per BEATS cycles.
- Full: exactly DEPTH rows can be queued in the FIFO in addition to the held row.

## Configuration
- GSAU_WB_BYPASS_EN defined:
  - When the FSM is IDLE and the FIFO is empty, an accepted row loads the hold register directly, skipping the FIFO.
  - The first beat appears in cycle T+1 and wb_count stays 0.
- GSAU_WB_BYPASS_EN undefined: every row passes through the FIFO; latency is T+2.
- Ordering, full/empty behaviour and done reporting are identical in both builds.

## Structure
- The shared systolic package (sys_arr_pkg) holds:
  - the row typedef wb_row_t {logic [ROW_W-1:0] psum; logic [DST_W-1:0] vdst;};
  - the state enum wb_state_t {IDLE, WRITE};
  - ROW_W/DST_W defaults.
- One sub-module, gsau_wb_fifo: show-ahead circular FIFO of wb_row_t with wrapping read/write pointers plus an extra wrap bit for full/empty, and a count output.
- The FSM, hold register and beat counter live in the top module.

## Test plan
- Single row, psum=row of 32-bit words 0..15, dst=0x21, veg_wr_ready=1:
  - four beats with beat indices 0..3 and data words 0-3, 4-7, 8-11, 12-15;
  - first beat at T+2 (T+1 with bypass);
  - sb_done_valid pulse with vdst 0x21 one cycle after beat 3.
- Stall: veg_wr_ready low for 5 cycles during beat 2 → beat 2 outputs stable throughout; no done pulse until beat 3 is accepted.
- Fill: hold veg_wr_ready=0 and push 5 rows (DEPTH=4) → 1 row held, wb_count=4, wb_output_ready=0. Then release → dsts drain in push order, done pulses every 4 cycles with no bubble.
- Simultaneous push/pop: push a row in the cycle the last beat is accepted with one row queued → wb_count unchanged, next row starts the following cycle.
- Reset asserted asynchronously mid-beat 1 → all outputs return to reset values immediately, with no done pulse. After release a new row dst 0x05 writes normally.
- Duplicate dst 0x10 pushed twice → two complete writes and two done pulses, both with vdst 0x10.
